dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared definitions for the data-memory responder: default
//            geometry, controller state encoding and the location of the
//            optional memory-mapped counter registers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Default geometry: 4096 words of 32 bits.
  localparam int c_addr_w_default = 12;
  localparam int c_data_w_default = 32;

  // Controller states.
  typedef logic [0:0] state_t;
  localparam logic [0:0] c_st_clear = 1'b0;  // zero-filling storage
  localparam logic [0:0] c_st_ready = 1'b1;  // serving requests

  // Counter registers sit at the top of the address space. They are given
  // as distances below the all-ones address so any ADDR_W can use them:
  // all-ones - 0 is the cycle counter, all-ones - 1 is the store counter.
  localparam int c_mmio_cyc_ofs = 0;
  localparam int c_mmio_stc_ofs = 1;

  // Source of the registered load data.
  localparam logic [1:0] c_sel_zero = 2'd0;  // q forced to zero
  localparam logic [1:0] c_sel_mem  = 2'd1;  // q from the storage read port
  localparam logic [1:0] c_sel_hold = 2'd2;  // q from the holding register

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Storage for the data-memory responder: one synchronous write
//            port and one registered read port. No reset, so it maps onto
//            block RAM.
// Ports    : clk      - clock
//            i_we     - write enable
//            i_waddr  - write word address
//            i_wdata  - write data
//            i_re     - read enable
//            i_raddr  - read word address
//            o_rdata  - read data, valid the cycle after i_re
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = c_addr_w_default,
  parameter int DATA_W = c_data_w_default
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Processor data-memory responder. After reset it zero-fills
//            every word (ready low), then serves one load or store per
//            cycle with a one-cycle registered result. Stores write through
//            to q.
//            Optional feature macro: DMEM_RESPONDER_MMIO_EN adds two
//            read-only counters at the top two addresses (cycle count at
//            all-ones, accepted-store count just below).
// Ports    : clock   - clock, rising edge
//            reset   - synchronous reset, active low
//            address - word address
//            data    - store data
//            wren    - 1 = store, 0 = load
//            q       - registered load data
//            ready   - high while requests are accepted
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = c_addr_w_default,
  parameter int DATA_W = c_data_w_default
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic              ready
);

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [1:0]        sel_q,     sel_d;
  logic [DATA_W-1:0] hold_q,    hold_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  logic              mmio_hit;
  logic [DATA_W-1:0] mmio_rdata;

`ifdef DMEM_RESPONDER_MMIO_EN
  localparam logic [ADDR_W-1:0] c_all_ones = '1;
  localparam logic [ADDR_W-1:0] c_cyc_addr = c_all_ones - ADDR_W'(c_mmio_cyc_ofs);
  localparam logic [ADDR_W-1:0] c_stc_addr = c_all_ones - ADDR_W'(c_mmio_stc_ofs);

  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] st_cnt_q,  st_cnt_d;

  always_comb begin
    mmio_hit   = (address == c_cyc_addr) || (address == c_stc_addr);
    mmio_rdata = (address == c_cyc_addr) ? DATA_W'(cyc_cnt_q) : DATA_W'(st_cnt_q);
    cyc_cnt_d  = cyc_cnt_q + 32'd1;
    st_cnt_d   = st_cnt_q;
    // Stores to the counter addresses are still accepted stores.
    if ((state_q == c_st_ready) && wren) begin
      st_cnt_d = st_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cyc_cnt_q <= 32'd0;
      st_cnt_q  <= 32'd0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      st_cnt_q  <= st_cnt_d;
    end
  end
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = '0;
`endif

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    sel_d     = c_sel_zero;
    hold_d    = hold_q;
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = data;
    mem_re    = 1'b0;

    case (state_q)
      c_st_clear: begin
        // Requests are ignored; q stays at zero via c_sel_zero.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) begin
          state_d = c_st_ready;
        end
      end
      default: begin
        if (wren) begin
          // Write-through: q shows the store data, even for counter addresses.
          mem_we = !mmio_hit;
          sel_d  = c_sel_hold;
          hold_d = data;
        end else if (mmio_hit) begin
          sel_d  = c_sel_hold;
          hold_d = mmio_rdata;
        end else begin
          mem_re = 1'b1;
          sel_d  = c_sel_mem;
        end
      end
    endcase

    // A request on a reset edge must not touch storage.
    if (!reset) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= c_st_clear;
      clr_ptr_q <= '0;
      sel_q     <= c_sel_zero;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clock),
    .i_we    (mem_we),
    .i_waddr (mem_waddr),
    .i_wdata (mem_wdata),
    .i_re    (mem_re),
    .i_raddr (address),
    .o_rdata (mem_rdata)
  );

  // Every source is a register, so q changes only after a clock edge.
  always_comb begin
    case (sel_q)
      c_sel_mem:  q = mem_rdata;
      c_sel_hold: q = hold_q;
      default:    q = '0;
    endcase
  end

  assign ready = (state_q == c_st_ready);

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder (12-bit
//            address, 32-bit data). Optional counter checks are compiled
//            when DMEM_RESPONDER_MMIO_EN is defined; otherwise the top
//            addresses are exercised as ordinary storage.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4096;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q;
  logic              ready;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q),
    .ready   (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run a full clear after reset release: ready must stay low for the first
  // DEPTH-1 edges with q at zero, and be high after edge DEPTH.
  task automatic clear_run(input string tag);
    int early_ready = 0;
    int q_nonzero   = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (i < DEPTH && ready !== 1'b0) early_ready++;
      if (q !== 32'h0) q_nonzero++;
    end
    chk({tag, "_ready_low"}, 32'(early_ready), 32'd0);
    chk({tag, "_q_zero"},    32'(q_nonzero),   32'd0);
    chk({tag, "_ready_up"},  {31'd0, ready},   32'd1);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a);
    wren    = 1'b0;
    address = a;
    tick();
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wren    = 1'b1;
    address = a;
    data    = d;
    tick();
    wren    = 1'b0;
  endtask

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    int          busy_drop;

    reset   = 1'b0;
    address = '0;
    data    = '0;
    wren    = 1'b0;

    // Reset held for three edges.
    tick(); tick(); tick();
    chk("reset_q",     q,              32'h0);
    chk("reset_ready", {31'd0, ready}, 32'd0);

    // Release; a store is presented throughout the clear and must be ignored.
    reset   = 1'b1;
    wren    = 1'b1;
    address = 12'h005;
    data    = 32'hFFFF_FFFF;
    clear_run("clear1");
    wren    = 1'b0;

    // Freshly cleared words read as zero, one cycle after the request.
    load(12'h000); chk("load_000", q, 32'h0);
    load(12'h7FF); chk("load_7ff", q, 32'h0);
    load(12'hFFD); chk("load_ffd", q, 32'h0);
    load(12'h005); chk("load_005_clear_store", q, 32'h0);

    // Write-through, then read-after-write, then a neighbour.
    store(12'h010, 32'hDEAD_BEEF); chk("store_010_wt", q, 32'hDEAD_BEEF);
    load(12'h010);                 chk("load_010",     q, 32'hDEAD_BEEF);
    load(12'h011);                 chk("load_011",     q, 32'h0);

    // Back-to-back requests, no stalls.
    busy_drop = 0;
    store(12'h100, 32'h1111_1111); if (!ready) busy_drop++;
    store(12'h101, 32'h2222_2222); if (!ready) busy_drop++;
    load(12'h100);                 chk("b2b_load_100", q, 32'h1111_1111);
    load(12'h101);                 chk("b2b_load_101", q, 32'h2222_2222);
    load(12'h010);                 chk("b2b_load_010", q, 32'hDEAD_BEEF);
    chk("b2b_ready_held", 32'(busy_drop), 32'd0);

`ifndef DMEM_RESPONDER_MMIO_EN
    // Top addresses are plain storage in the default build.
    store(12'hFFF, 32'hCAFE_F00D);
    store(12'hFFE, 32'h0BAD_F00D);
    load(12'hFFF); chk("plain_fff", q, 32'hCAFE_F00D);
    load(12'hFFE); chk("plain_ffe", q, 32'h0BAD_F00D);
`endif

    // Reset mid-READY, then again 2000 cycles into the clear.
    store(12'h020, 32'h1234_5678); chk("store_020_wt", q, 32'h1234_5678);
    reset = 1'b0;
    tick();
    chk("rst2_q",     q,              32'h0);
    chk("rst2_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 2000; i++) tick();
    chk("mid_clear_ready", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rst3_q", q, 32'h0);
    reset = 1'b1;
    clear_run("clear3");
    load(12'h020); chk("load_020_after_reset", q, 32'h0);
    load(12'h010); chk("load_010_after_reset", q, 32'h0);

`ifdef DMEM_RESPONDER_MMIO_EN
    // Store counter was cleared by the last reset.
    store(12'h030, 32'h0000_0001);
    store(12'h031, 32'h0000_0002);
    store(12'h032, 32'h0000_0003);
    load(12'hFFE); chk("mmio_store_cnt_3", q, 32'd3);

    // Cycle counter advances by exactly the cycle distance.
    load(12'hFFF); v1 = q;
    for (int i = 0; i < 9; i++) load(12'h000);
    load(12'hFFF); v2 = q;
    chk("mmio_cyc_delta_10", v2 - v1, 32'd10);

    // Store to the cycle counter: write-through only, counter untouched.
    store(12'hFFF, 32'hAAAA_AAAA); chk("mmio_store_wt", q, 32'hAAAA_AAAA);
    load(12'hFFF);                 chk("mmio_cyc_unaffected", q, v2 + 32'd2);
    load(12'hFFE);                 chk("mmio_store_cnt_4", q, 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
